// File: rtl/cska_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cska_pkg
// Description : Shared types and constants for the sequential carry-skip
//               adder controller and its 4-bit adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
package cska_pkg;

  // Width of the reused adder slice; operands are processed one slice per clock.
  localparam int NIBBLE_W = 4;

  // Controller states; encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : cska_pkg
`default_nettype wire

// File: rtl/carry_skip_adder.sv
`default_nettype none
// ============================================================================
// Module      : carry_skip_adder
// Description : Purely combinational 4-bit carry-skip adder slice. When every
//               bit propagates, the carry-in bypasses the ripple chain.
// Revision    : 1.0 - initial release
// ============================================================================
module carry_skip_adder
  import cska_pkg::*;
(
  output logic [NIBBLE_W-1:0] sum,
  output logic                carry,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin
);

  logic [NIBBLE_W-1:0] prop;
  logic [NIBBLE_W-1:0] gen;
  logic [NIBBLE_W:0]   rip;

  // Ripple chain for the sum bits, skip mux for the slice carry-out.
  always_comb begin
    prop   = a ^ b;
    gen    = a & b;
    rip    = '0;
    rip[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      rip[i+1] = gen[i] | (prop[i] & rip[i]);
    end
    sum   = prop ^ rip[NIBBLE_W-1:0];
    carry = (&prop) ? cin : rip[NIBBLE_W];
  end

endmodule : carry_skip_adder
`default_nettype wire

// File: rtl/cska_seq_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cska_seq_add_ctrl
// Description : Performs one WIDTH-bit addition by stepping a single 4-bit
//               carry-skip slice across the operands, LSB nibble first, with
//               valid/ready handshakes on both the operand and result sides.
// Revision    : 1.0 - initial release
// ============================================================================
module cska_seq_add_ctrl
  import cska_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int                NIBBLES  = WIDTH / NIBBLE_W;
  localparam int                IDX_W    = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic [WIDTH-1:0]      a_q,     a_d;
  logic [WIDTH-1:0]      b_q,     b_d;
  logic [WIDTH-1:0]      sum_q,   sum_d;
  logic                  carry_q, carry_d;
  logic                  cout_q,  cout_d;

  logic [NIBBLE_W-1:0]   slice_a;
  logic [NIBBLE_W-1:0]   slice_b;
  logic [NIBBLE_W-1:0]   slice_sum;
  logic                  slice_carry;

  // The slice always sees the nibble selected by the step counter.
  assign slice_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign slice_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  carry_skip_adder u_slice (slice_sum, slice_carry, slice_a, slice_b, carry_q);

  // Next-state logic: accept in IDLE, one nibble per clock in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = slice_sum;
        carry_d = slice_carry;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_carry;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        // Returning to IDLE first means no accept can share the handshake cycle.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule : cska_seq_add_ctrl
`default_nettype wire

// File: tb/tb_cska_seq_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cska_seq_add_ctrl
// Description : Self-checking bench for cska_seq_add_ctrl (WIDTH=16). Expected
//               results come from plain integer addition of the operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cska_seq_add_ctrl;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int pass_cnt;
  int total_cnt;

  cska_seq_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the full-width arithmetic sum including carry-out.
  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, wait for the result, return it with the latency seen.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        output logic [W-1:0] s, output logic co, output int lat,
                        output bit got_valid);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = cv;
    step();
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom);
    lat      = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    got_valid = out_valid;
    s         = sum;
    co        = cout;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    step();
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (sum !== 16'h0000) $display("FAIL reset_sum: got %h expected 0000", sum);
    else pass_cnt++;
    total_cnt++;
    if (cout !== 1'b0) $display("FAIL reset_cout: got %b expected 0", cout);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [W-1:0] av [3];
    logic [W-1:0] bv [3];
    logic         cv [3];
    logic [W-1:0] s;
    logic         co;
    logic [W:0]   exp;
    int           lat;
    bit           gv;
    av[0] = 16'h1234; bv[0] = 16'h1111; cv[0] = 1'b0;
    av[1] = 16'hFFFF; bv[1] = 16'h0000; cv[1] = 1'b1;
    av[2] = 16'hFFFF; bv[2] = 16'hFFFF; cv[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = model_add(av[i], bv[i], cv[i]);
      run_op(av[i], bv[i], cv[i], s, co, lat, gv);
      total_cnt++;
      if (!gv || lat != 4) $display("FAIL directed%0d_latency: got %0d edges (valid=%b) expected 4", i, lat, gv);
      else pass_cnt++;
      total_cnt++;
      if (s !== exp[W-1:0]) $display("FAIL directed%0d_sum: got %h expected %h", i, s, exp[W-1:0]);
      else pass_cnt++;
      total_cnt++;
      if (co !== exp[W]) $display("FAIL directed%0d_cout: got %b expected %b", i, co, exp[W]);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] exp;
    int         lat;
    exp      = model_add(16'hA5C3, 16'h5A4D, 1'b1);
    in_valid = 1'b1;
    a        = 16'hA5C3;
    b        = 16'h5A4D;
    cin      = 1'b1;
    step();
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    for (int k = 0; k < 10; k++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== exp)
        $display("FAIL stall%0d: got valid=%b ready=%b result=%h expected valid=1 ready=0 result=%h",
                 k, out_valid, in_ready, {cout, sum}, exp);
      else pass_cnt++;
      in_valid = ~in_valid;
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom);
      step();
    end
    // Handshake with in_valid still high: the operand must not be taken.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    total_cnt++;
    if ({cout, sum} !== exp) $display("FAIL stall_handshake_result: got %h expected %h", {cout, sum}, exp);
    else pass_cnt++;
    step();
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stall_after_handshake: got valid=%b busy=%b ready=%b expected 0 0 1",
               out_valid, busy, in_ready);
    else pass_cnt++;
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] s;
    logic         co;
    logic [W:0]   exp;
    int           lat;
    bit           gv;
    bit           seen;
    in_valid = 1'b1;
    a        = 16'h7777;
    b        = 16'h9999;
    cin      = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0)
      $display("FAIL midrun_reset_state: got valid=%b busy=%b sum=%h cout=%b expected 0 0 0000 0",
               out_valid, busy, sum, cout);
    else pass_cnt++;
    step();
    step();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    total_cnt++;
    if (seen) $display("FAIL midrun_no_out_valid: got out_valid pulse expected none");
    else pass_cnt++;
    exp = model_add(16'h0F0F, 16'h00F1, 1'b0);
    run_op(16'h0F0F, 16'h00F1, 1'b0, s, co, lat, gv);
    total_cnt++;
    if (!gv || {co, s} !== exp)
      $display("FAIL midrun_next_op: got valid=%b result=%h expected 1 %h", gv, {co, s}, exp);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W:0] expq [$];
    logic [W:0] held;
    logic [W:0] front;
    bit         held_ok;
    int         accepts;
    int         results;
    int         cycles;
    accepts = 0;
    results = 0;
    cycles  = 0;
    held_ok = 1'b0;
    held    = '0;
    while ((accepts < 1000 || expq.size() != 0) && cycles < 40000) begin
      in_valid  = (accepts < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      if (out_valid && held_ok) begin
        total_cnt++;
        if ({cout, sum} !== held) $display("FAIL rand_stall_stable: got %h expected %h", {cout, sum}, held);
        else pass_cnt++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model_add(a, b, cin));
        accepts++;
      end
      held_ok = 1'b0;
      if (out_valid && out_ready) begin
        total_cnt++;
        if (expq.size() == 0) begin
          $display("FAIL rand_unexpected_result: got %h expected no result", {cout, sum});
        end else begin
          front = expq.pop_front();
          if ({cout, sum} !== front) $display("FAIL rand_result%0d: got %h expected %h", results, {cout, sum}, front);
          else pass_cnt++;
        end
        results++;
      end else if (out_valid) begin
        held    = {cout, sum};
        held_ok = 1'b1;
      end
      step();
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total_cnt++;
    if (results != 1000 || expq.size() != 0)
      $display("FAIL rand_count: got %0d results with %0d pending expected 1000 with 0 pending",
               results, expq.size());
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_cska_seq_add_ctrl
`default_nettype wire
